// File: rtl/alu_defs.sv
// rtl/alu_defs.sv - opcode constants, FSM state encoding and opcode legality for the ALU share arbiter
package alu_defs;

    localparam logic [3:0] OP_AND = 4'b0000;
    localparam logic [3:0] OP_OR  = 4'b0001;
    localparam logic [3:0] OP_ADD = 4'b0010;
    localparam logic [3:0] OP_SUB = 4'b0110;
    localparam logic [3:0] OP_SLT = 4'b0111;
    localparam logic [3:0] OP_NOR = 4'b1100;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_RESP = 2'd2
    } state_e;

    function automatic logic is_legal_op(input logic [3:0] op);
        case (op)
            OP_AND, OP_OR, OP_ADD, OP_SUB, OP_SLT, OP_NOR: is_legal_op = 1'b1;
            default:                                      is_legal_op = 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/rr_arbiter2.sv
// rtl/rr_arbiter2.sv - two-way round-robin grant; on a tie the requester that did not win last time wins
module rr_arbiter2 (
    input  logic valid0,
    input  logic valid1,
    input  logic last_grant,
    output logic grant,
    output logic grant_valid
);

    assign grant_valid = valid0 | valid1;
    assign grant       = (valid0 && valid1) ? ~last_grant : valid1;

endmodule

// File: rtl/alu_share_arbiter.sv
// rtl/alu_share_arbiter.sv - shares one combinational ALU between the EX stage (port 0) and the branch/address unit (port 1)
module alu_share_arbiter
    import alu_defs::*;
#(
    parameter int WIDTH = 32,
    parameter int OPW   = 4
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [WIDTH-1:0] req0_data1,
    input  logic [WIDTH-1:0] req0_data2,
    input  logic [OPW-1:0]   req0_op,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [WIDTH-1:0] req1_data1,
    input  logic [WIDTH-1:0] req1_data2,
    input  logic [OPW-1:0]   req1_op,
    output logic [WIDTH-1:0] alu_data1,
    output logic [WIDTH-1:0] alu_data2,
    output logic [OPW-1:0]   alu_operation,
    input  logic [WIDTH-1:0] alu_result,
    input  logic             alu_zero,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic             rsp_id,
    output logic [WIDTH-1:0] rsp_result,
    output logic             rsp_zero,
    output logic             rsp_illegal
);

    state_e           state_q, state_d;
    logic             last_grant_q, last_grant_d;
    logic [WIDTH-1:0] opa_q, opa_d;
    logic [WIDTH-1:0] opb_q, opb_d;
    logic [OPW-1:0]   op_q, op_d;
    logic             id_q, id_d;
    logic             rsp_id_q, rsp_id_d;
    logic [WIDTH-1:0] rsp_result_q, rsp_result_d;
    logic             rsp_zero_q, rsp_zero_d;
    logic             rsp_illegal_q, rsp_illegal_d;

    logic             grant;
    logic             grant_valid;
    logic             accept_ok;
    logic             accept;
    logic             op_legal;

    rr_arbiter2 u_arb (
        .valid0      (req0_valid),
        .valid1      (req1_valid),
        .last_grant  (last_grant_q),
        .grant       (grant),
        .grant_valid (grant_valid)
    );

    // A held response may be retired and replaced in the same cycle, giving back-to-back issue.
    assign accept_ok  = (state_q == ST_IDLE) || ((state_q == ST_RESP) && rsp_ready);
    assign accept     = accept_ok && grant_valid;
    assign req0_ready = accept && !grant;
    assign req1_ready = accept && grant;

    // Opcodes wider than the 4-bit table are only legal when the extra bits are zero.
    assign op_legal = is_legal_op(op_q[3:0]) && ((op_q >> 4) == '0);

    always_comb begin
        state_d       = state_q;
        last_grant_d  = last_grant_q;
        opa_d         = opa_q;
        opb_d         = opb_q;
        op_d          = op_q;
        id_d          = id_q;
        rsp_id_d      = rsp_id_q;
        rsp_result_d  = rsp_result_q;
        rsp_zero_d    = rsp_zero_q;
        rsp_illegal_d = rsp_illegal_q;

        if (accept) begin
            opa_d        = grant ? req1_data1 : req0_data1;
            opb_d        = grant ? req1_data2 : req0_data2;
            op_d         = grant ? req1_op    : req0_op;
            id_d         = grant;
            last_grant_d = grant;
        end

        case (state_q)
            ST_IDLE: begin
                if (accept) state_d = ST_EXEC;
            end
            ST_EXEC: begin
                rsp_id_d      = id_q;
                rsp_result_d  = op_legal ? alu_result : '0;
                rsp_zero_d    = op_legal && alu_zero;
                rsp_illegal_d = !op_legal;
                state_d       = ST_RESP;
            end
            ST_RESP: begin
                if (rsp_ready) state_d = accept ? ST_EXEC : ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= ST_IDLE;
            last_grant_q  <= 1'b1;
            opa_q         <= '0;
            opb_q         <= '0;
            op_q          <= '0;
            id_q          <= 1'b0;
            rsp_id_q      <= 1'b0;
            rsp_result_q  <= '0;
            rsp_zero_q    <= 1'b0;
            rsp_illegal_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            last_grant_q  <= last_grant_d;
            opa_q         <= opa_d;
            opb_q         <= opb_d;
            op_q          <= op_d;
            id_q          <= id_d;
            rsp_id_q      <= rsp_id_d;
            rsp_result_q  <= rsp_result_d;
            rsp_zero_q    <= rsp_zero_d;
            rsp_illegal_q <= rsp_illegal_d;
        end
    end

    assign alu_data1     = opa_q;
    assign alu_data2     = opb_q;
    assign alu_operation = op_q;
    assign rsp_valid     = (state_q == ST_RESP);
    assign rsp_id        = rsp_id_q;
    assign rsp_result    = rsp_result_q;
    assign rsp_zero      = rsp_zero_q;
    assign rsp_illegal   = rsp_illegal_q;

endmodule

// File: tb/tb_alu_share_arbiter.sv
// tb/tb_alu_share_arbiter.sv - randomized and directed checks of alu_share_arbiter against a transaction-level model
module tb_alu_share_arbiter;

    logic        clk;
    logic        reset_n;
    logic        v [2];
    logic [31:0] a [2];
    logic [31:0] b [2];
    logic [3:0]  o [2];
    logic        req0_ready, req1_ready;
    logic [31:0] alu_data1, alu_data2, alu_result;
    logic [3:0]  alu_operation;
    logic        alu_zero;
    logic        rsp_valid, rsp_rdy, rsp_id, rsp_zero, rsp_illegal;
    logic [31:0] rsp_result;

    int total = 0;
    int bad   = 0;

    alu_share_arbiter #(.WIDTH(32), .OPW(4)) dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .req0_valid    (v[0]),
        .req0_ready    (req0_ready),
        .req0_data1    (a[0]),
        .req0_data2    (b[0]),
        .req0_op       (o[0]),
        .req1_valid    (v[1]),
        .req1_ready    (req1_ready),
        .req1_data1    (a[1]),
        .req1_data2    (b[1]),
        .req1_op       (o[1]),
        .alu_data1     (alu_data1),
        .alu_data2     (alu_data2),
        .alu_operation (alu_operation),
        .alu_result    (alu_result),
        .alu_zero      (alu_zero),
        .rsp_valid     (rsp_valid),
        .rsp_ready     (rsp_rdy),
        .rsp_id        (rsp_id),
        .rsp_result    (rsp_result),
        .rsp_zero      (rsp_zero),
        .rsp_illegal   (rsp_illegal)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic ref_legal(input logic [3:0] op);
        return (op == 4'd0) || (op == 4'd1) || (op == 4'd2) ||
               (op == 4'd6) || (op == 4'd7) || (op == 4'd12);
    endfunction

    function automatic logic [31:0] ref_alu(input logic [31:0] x, input logic [31:0] y, input logic [3:0] op);
        case (op)
            4'd0:    return x & y;
            4'd1:    return x | y;
            4'd2:    return x + y;
            4'd6:    return x - y;
            4'd7:    return ($signed(x) < $signed(y)) ? 32'd1 : 32'd0;
            4'd12:   return ~(x | y);
            default: return 32'd0;
        endcase
    endfunction

    // External ALU stand-in; illegal opcodes produce junk so masking by the DUT is visible.
    always_comb begin
        alu_result = ref_legal(alu_operation) ? ref_alu(alu_data1, alu_data2, alu_operation) : 32'hDEAD_BEEF;
        alu_zero   = ref_legal(alu_operation) ? (alu_result == 32'd0) : 1'b1;
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Transaction-level model: an op occupies one execute cycle, then one held response slot.
    logic        m_exec, m_held, m_last;
    logic [31:0] m_ea, m_eb;
    logic [3:0]  m_eo;
    logic [33:0] q0 [$];
    logic [33:0] q1 [$];
    int          q_ord [$];
    logic [34:0] snap;
    logic        snap_valid;
    int          waitc [2];
    logic        acc [2];
    int          resp_cnt = 0;

    task automatic model_reset();
        m_exec = 0; m_held = 0; m_last = 1; snap_valid = 0;
        q0.delete(); q1.delete(); q_ord.delete();
        waitc[0] = 0; waitc[1] = 0;
    endtask

    task automatic cycle();
        logic ok, r0, r1, lg;
        logic [31:0] res;
        logic [33:0] e;
        int g, id, oth;
        acc[0] = 0; acc[1] = 0;
        @(negedge clk);
        ok = !m_exec && (!m_held || rsp_rdy);
        g = -1;
        if (v[0] && v[1]) g = m_last ? 0 : 1;
        else if (v[0])    g = 0;
        else if (v[1])    g = 1;
        r0 = ok && (g == 0);
        r1 = ok && (g == 1);
        chk("req0_ready", req0_ready, r0);
        chk("req1_ready", req1_ready, r1);
        chk("both_ready", req0_ready & req1_ready, 0);
        chk("rsp_valid", rsp_valid, m_held);
        if (m_exec) chk("alu_ops", {alu_operation, alu_data1, alu_data2}, {m_eo, m_ea, m_eb});
        if (m_held && snap_valid)
            chk("rsp_stable", {rsp_id, rsp_illegal, rsp_zero, rsp_result}, snap);
        snap_valid = m_held && !rsp_rdy;
        snap = {rsp_id, rsp_illegal, rsp_zero, rsp_result};
        if (m_held && rsp_rdy) begin
            if (q_ord.size() == 0) chk("dup_rsp", 1, 0);
            else begin
                id = q_ord.pop_front();
                chk("rsp_id", rsp_id, id);
                if ((rsp_id ? q1.size() : q0.size()) == 0) chk("dup_id", 1, 0);
                else begin
                    e = rsp_id ? q1.pop_front() : q0.pop_front();
                    chk("rsp_data", {rsp_illegal, rsp_zero, rsp_result}, e);
                end
            end
            m_held = 0;
            resp_cnt++;
        end
        if (m_exec) begin m_held = 1; m_exec = 0; end
        if (ok && g >= 0) begin
            lg  = ref_legal(o[g]);
            res = lg ? ref_alu(a[g], b[g], o[g]) : 32'd0;
            e   = {!lg, lg && (res == 32'd0), res};
            if (g == 0) q0.push_back(e); else q1.push_back(e);
            q_ord.push_back(g);
            m_exec = 1; m_ea = a[g]; m_eb = b[g]; m_eo = o[g];
            m_last = g[0];
            acc[g] = 1;
            waitc[g] = 0;
            oth = 1 - g;
            if (v[oth]) begin
                waitc[oth]++;
                chk("fairness", waitc[oth] <= 1, 1);
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int i, input logic [31:0] x, input logic [31:0] y, input logic [3:0] op);
        v[i] = 1; a[i] = x; b[i] = y; o[i] = op;
    endtask

    task automatic drain();
        v[0] = 0; v[1] = 0; rsp_rdy = 1;
        repeat (3) cycle();
        rsp_rdy = 0;
    endtask

    task automatic do_reset();
        reset_n = 0;
        #1;
        chk("rst_alu", {alu_data1, alu_data2}, 0);
        chk("rst_rsp", {alu_operation, rsp_valid, rsp_id, rsp_result, rsp_zero, rsp_illegal}, 0);
        model_reset();
        @(negedge clk);
        reset_n = 1;
        @(posedge clk);
        #1;
    endtask

    int gseq [$];
    logic [3:0] legal_ops [6];

    initial begin
        legal_ops = '{4'd0, 4'd1, 4'd2, 4'd6, 4'd7, 4'd12};
        for (int i = 0; i < 2; i++) begin v[i] = 0; a[i] = 0; b[i] = 0; o[i] = 0; end
        rsp_rdy = 0;
        reset_n = 1;
        repeat (2) @(posedge clk);
        #1;
        do_reset();

        // ADD 2,1 from port 0
        set_req(0, 32'd2, 32'd1, 4'd2);
        cycle();
        chk("t1_accept", acc[0], 1);
        v[0] = 0;
        cycle();
        chk("t1_rsp", {rsp_valid, rsp_id, rsp_zero, rsp_result}, {1'b1, 1'b0, 1'b0, 32'd3});
        drain();

        // SUB 2,2 from port 1 held for five cycles while port 0 waits
        set_req(1, 32'd2, 32'd2, 4'd6);
        cycle();
        v[1] = 0;
        set_req(0, 32'd1, 32'd1, 4'd0);
        cycle();
        repeat (5) cycle();
        chk("t2_rsp", {rsp_valid, rsp_id, rsp_zero, rsp_result}, {1'b1, 1'b1, 1'b1, 32'd0});
        rsp_rdy = 1;
        cycle();
        chk("t2_b2b", acc[0], 1);
        drain();

        // Alternating grants from reset with both ports always requesting
        do_reset();
        set_req(0, 32'd10, 32'd6, 4'd0);
        set_req(1, 32'd10, 32'd5, 4'd1);
        rsp_rdy = 1;
        for (int k = 0; k < 8; k++) begin
            cycle();
            if (acc[0]) gseq.push_back(0);
            if (acc[1]) gseq.push_back(1);
            if (k == 2) chk("t3_first", rsp_result, 32'd2);
        end
        chk("t3_ngrants", gseq.size(), 4);
        for (int k = 0; k < gseq.size() && k < 4; k++) chk("t3_order", gseq[k], k % 2);
        drain();

        // Signed SLT, then an illegal opcode
        set_req(0, 32'hFFFF_FFF6, 32'd5, 4'd7);
        cycle();
        v[0] = 0;
        cycle();
        chk("t4_slt", {rsp_illegal, rsp_result}, {1'b0, 32'd1});
        rsp_rdy = 1;
        set_req(0, 32'd7, 32'd7, 4'b1111);
        cycle();
        v[0] = 0;
        rsp_rdy = 0;
        cycle();
        chk("t4_illegal", {rsp_valid, rsp_illegal, rsp_zero, rsp_result}, {1'b1, 1'b1, 1'b0, 32'd0});
        drain();

        // Reset during EXEC and during RESP
        set_req(0, 32'd4, 32'd4, 4'd2);
        cycle();
        v[0] = 0;
        do_reset();
        repeat (3) cycle();
        set_req(1, 32'd4, 32'd4, 4'd2);
        cycle();
        v[1] = 0;
        cycle();
        do_reset();
        repeat (3) cycle();
        set_req(0, 32'd1, 32'd2, 4'd2);
        set_req(1, 32'd3, 32'd4, 4'd2);
        cycle();
        chk("rst_tie", {acc[0], acc[1]}, 2'b10);
        v[0] = 0;
        drain();

        // Random stress
        begin
            int base, n;
            base = resp_cnt;
            n = 0;
            while ((resp_cnt - base) < 1000 && n < 20000) begin
                for (int i = 0; i < 2; i++) begin
                    if (!v[i] && $urandom_range(3) != 0) begin
                        v[i] = 1;
                        a[i] = $urandom;
                        b[i] = ($urandom_range(7) == 0) ? a[i] : $urandom;
                        o[i] = ($urandom_range(9) == 0) ? 4'($urandom) : legal_ops[$urandom_range(5)];
                    end else if (v[i] && $urandom_range(31) == 0) begin
                        v[i] = 0;
                        waitc[i] = 0;
                    end
                end
                rsp_rdy = ($urandom_range(2) != 0);
                cycle();
                for (int i = 0; i < 2; i++) if (acc[i]) v[i] = 0;
                n++;
            end
            if (n >= 20000) chk("stress_timeout", 1, 0);
            drain();
            chk("lost_rsp", q_ord.size() + q0.size() + q1.size(), 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
